// File: rtl/signal_debouncer.sv
// Per-channel input debouncer: a level change is accepted only after
// STABLE_CYCLES consecutive samples that differ from the current debounced state.
module signal_debouncer #(
  parameter int               WIDTH         = 1,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_STATE   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  localparam int             CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [WIDTH];

  // A matching sample or a disabled cycle discards any partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (!en || (in[i] == state[i])) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          state[i] <= in[i];
          cnt[i]   <= '0;
          rise[i]  <= in[i];
          fall[i]  <= ~in[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign any_edge = |{rise, fall};

endmodule

// File: tb/tb_signal_debouncer.sv
// Bench for signal_debouncer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a run-length reference model.
module tb_signal_debouncer;

  localparam int WIDTH  = 2;
  localparam int STABLE = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_edge;

  int tests = 0;
  int fails = 0;

  signal_debouncer #(
    .WIDTH(WIDTH),
    .STABLE_CYCLES(STABLE),
    .RESET_STATE(2'b00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in(in),
    .state(state),
    .rise(rise),
    .fall(fall),
    .any_edge(any_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a change is accepted when the number of consecutive enabled
  // samples differing from the debounced level reaches STABLE.
  logic [WIDTH-1:0] m_state;
  logic [WIDTH-1:0] m_rise;
  logic [WIDTH-1:0] m_fall;
  int               run [WIDTH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 2'b00;
      m_rise  = '0;
      m_fall  = '0;
      for (int i = 0; i < WIDTH; i++) run[i] = 0;
    end else begin
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (!en || in[i] == m_state[i]) begin
          run[i] = 0;
        end else begin
          run[i] = run[i] + 1;
          if (run[i] == STABLE) begin
            m_state[i] = in[i];
            run[i]     = 0;
            if (in[i]) m_rise[i] = 1'b1;
            else       m_fall[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit running = 1'b0;

  always @(negedge clk) begin
    if (running) begin
      check("model_state", 32'(state), 32'(m_state));
      check("model_rise",  32'(rise),  32'(m_rise));
      check("model_fall",  32'(fall),  32'(m_fall));
      check("model_any",   32'(any_edge), 32'(|{m_rise, m_fall}));
    end
  end

  // Drive inputs now, then return 1 time unit after the n-th rising edge.
  task automatic applyStimulus(input logic e, input logic [WIDTH-1:0] v, input int n);
    en = e;
    in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Literal expectations checked against both the DUT and the reference model.
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] s,
                             input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] f);
    check({name, "_state"}, 32'(state), 32'(s));
    check({name, "_rise"},  32'(rise),  32'(r));
    check({name, "_fall"},  32'(fall),  32'(f));
    check({name, "_any"},   32'(any_edge), 32'(|{r, f}));
    check({name, "_mstate"}, 32'(m_state), 32'(s));
    check({name, "_mpulse"}, 32'({m_rise, m_fall}), 32'({r, f}));
  endtask

  initial begin
    logic [WIDTH-1:0] cur_in;
    logic             cur_en;

    rst = 1'b1;
    en  = 1'b0;
    in  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 2'b00, 2'b00, 2'b00);
    rst     = 1'b0;
    running = 1'b1;

    // Single rise on channel 0 after exactly four edges
    applyStimulus(1'b1, 2'b01, 3);
    checkOutput("rise_pre", 2'b00, 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b01, 1);
    checkOutput("rise_hit", 2'b01, 2'b01, 2'b00);
    applyStimulus(1'b1, 2'b01, 1);
    checkOutput("rise_post", 2'b01, 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b00, 4);
    checkOutput("fall_back", 2'b00, 2'b00, 2'b01);

    // Glitch at sample 4 restarts the count
    applyStimulus(1'b1, 2'b01, 3);
    applyStimulus(1'b1, 2'b00, 1);
    checkOutput("glitch", 2'b00, 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b01, 3);
    checkOutput("glitch_wait", 2'b00, 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b01, 1);
    checkOutput("glitch_acc", 2'b01, 2'b01, 2'b00);
    applyStimulus(1'b1, 2'b01, 1);
    checkOutput("glitch_once", 2'b01, 2'b00, 2'b00);

    // Simultaneous falls on both channels
    applyStimulus(1'b1, 2'b11, 4);
    checkOutput("both_set", 2'b11, 2'b10, 2'b00);
    applyStimulus(1'b1, 2'b00, 3);
    checkOutput("both_wait", 2'b11, 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b00, 1);
    checkOutput("both_fall", 2'b00, 2'b00, 2'b11);
    applyStimulus(1'b1, 2'b00, 1);
    checkOutput("both_quiet", 2'b00, 2'b00, 2'b00);

    // Enable dropped mid-count clears progress
    applyStimulus(1'b1, 2'b01, 2);
    applyStimulus(1'b0, 2'b01, 3);
    checkOutput("en_low", 2'b00, 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b01, 3);
    checkOutput("en_fresh", 2'b00, 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b01, 1);
    checkOutput("en_acc", 2'b01, 2'b01, 2'b00);
    applyStimulus(1'b1, 2'b00, 4);
    checkOutput("en_back", 2'b00, 2'b00, 2'b01);

    // Asynchronous reset between edges discards a 3-sample partial count
    applyStimulus(1'b1, 2'b01, 3);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    applyStimulus(1'b1, 2'b01, 3);
    checkOutput("rst_fresh", 2'b00, 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b01, 1);
    checkOutput("rst_acc", 2'b01, 2'b01, 2'b00);

    // Randomized traffic: sticky inputs, occasional enable drops and resets
    cur_in = in;
    cur_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(3) == 0) cur_in = WIDTH'($urandom);
      cur_en = ($urandom_range(15) != 0);
      en = cur_en;
      in = cur_in;
      if ($urandom_range(199) == 0) begin
        #3 rst = 1'b1;
        #3 rst = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/signal_debouncer.md
SIGNAL_DEBOUNCER -- requirements
Module: signal_debouncer

Interface
REQ-001: The module SHALL have parameter WIDTH, default 1, giving the number of independent input channels.
REQ-002: The module SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive differing samples needed to accept a change; legal range 2..65535.
REQ-003: The module SHALL have parameter RESET_STATE, default 0 (WIDTH bits), giving the debounced state loaded on reset.
REQ-004: The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005: The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006: The module SHALL have port en, input, 1 bit: debounce enable.
REQ-007: The module SHALL have port in, input, WIDTH bits: already-synchronized external levels, sampled every rising clk edge.
REQ-008: The module SHALL have port state, output, WIDTH bits: registered debounced level per channel.
REQ-009: The module SHALL have port rise, output, WIDTH bits: one-cycle registered pulse on an accepted 0->1 change.
REQ-010: The module SHALL have port fall, output, WIDTH bits: one-cycle registered pulse on an accepted 1->0 change.
REQ-011: The module SHALL have port any_edge, output, 1 bit: combinational OR of all rise and fall bits.

Function
REQ-012: Each channel SHALL hold a private counter cnt[i], $clog2(STABLE_CYCLES) bits wide, with no sharing across channels.
REQ-013: At each edge with en=1 and in[i]==state[i]: cnt[i]<=0; state[i] is held; rise[i] and fall[i] <=0.
REQ-014: At each edge with en=1, in[i]!=state[i] and cnt[i]<STABLE_CYCLES-1: cnt[i]<=cnt[i]+1; state[i] is held; pulses <=0.
REQ-015: At each edge with en=1, in[i]!=state[i] and cnt[i]==STABLE_CYCLES-1: state[i]<=in[i]; cnt[i]<=0; rise[i]<=in[i]; fall[i]<=~in[i].
REQ-016: A change SHALL therefore be accepted on exactly the STABLE_CYCLES-th consecutive differing sampling edge; state and the pulse update on the same edge.
REQ-017: Any single sample equal to state[i] before acceptance SHALL restart the count from 0 (glitch rejection); partial counts are never retained.
REQ-018: rise[i] and fall[i] SHALL never both be 1, and SHALL each be high for exactly one cycle per accepted change.
REQ-019: At each edge with en=0, all cnt SHALL be cleared, state SHALL be held, and rise and fall SHALL be 0.
REQ-020: When en rises, counting SHALL start fresh from 0 at the first enabled edge.
REQ-021: Channels SHALL be fully independent: simultaneous acceptances on several channels SHALL all pulse in the same cycle.
REQ-022: Counter arithmetic SHALL never wrap, because acceptance at STABLE_CYCLES-1 always resets cnt to 0.

Reset
REQ-023: While rst=1, asynchronously: state=RESET_STATE, cnt=0, rise=0, fall=0, any_edge=0.
REQ-024: An assertion of rst in the middle of a count SHALL discard the partial count; no pulse is generated for the pending change.
REQ-025: After rst deasserts, the first rising clk edge SHALL be a normal sampling edge.

Verification (WIDTH=2, STABLE_CYCLES=4, RESET_STATE=0)
REQ-026: Reset, en=1, then in=2'b01 held -> state[0]=1 after the 4th edge; rise=2'b01 for exactly one cycle; any_edge=1 for that cycle only.
REQ-027: in[0]=1 for 3 edges, 0 for 1 edge, then 1 held -> no change until 4 further edges; exactly one rise pulse.
REQ-028: state=2'b11, then in=2'b00 held -> both fall bits pulse in the same cycle; state=2'b00.
REQ-029: in=2'b01 with en toggled low after 2 edges, then high -> state unchanged until 4 edges after en returns high.
REQ-030: rst asserted after 3 differing edges, with no clk edge -> state=0 immediately; pulses 0; a fresh 4-edge count is required after release.
